axi_cmd_arbiter: RTL and testbench

AXI_CMD_ARBITER -- requirements
Module: axi_cmd_arbiter

---
 rtl/axi_cmd_arbiter.sv | 82 ++++++++
 tb/tb_axi_cmd_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/axi_cmd_arbiter.sv
// axi_cmd_arbiter: round-robin write/read command arbiter with one outstanding
// AXI command, ready/valid issue handshake and a WAIT-state timeout abort.
module axi_cmd_arbiter #(
    parameter int P_AXI_ADDR_WIDTH = 32,
    parameter int P_TIMEOUT        = 1024
) (
    input  logic                        i_user_clk,
    input  logic                        i_rst,
    input  logic                        i_wr_en,
    input  logic [P_AXI_ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [7:0]                  i_wr_length,
    output logic                        o_wr_ready,
    input  logic                        i_rd_en,
    input  logic [P_AXI_ADDR_WIDTH-1:0] i_rd_addr,
    input  logic [7:0]                  i_rd_length,
    output logic                        o_rd_ready,
    output logic                        o_axi_cmd_valid,
    output logic                        o_axi_cmd_wr,
    output logic [P_AXI_ADDR_WIDTH-1:0] o_axi_cmd_addr,
    output logic [7:0]                  o_axi_cmd_length,
    input  logic                        i_axi_cmd_ready,
    input  logic                        i_axi_wr_done,
    input  logic                        i_axi_rd_done,
    output logic                        o_busy,
    output logic                        o_timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam logic [15:0] L_TOUT_LAST = 16'(P_TIMEOUT - 1);
    state_t      state, state_nxt;
    logic        last_wr;
    logic [15:0] wait_cnt;
    logic        wr_grant, rd_grant, done_hit, tout_hit;
    always_ff @(posedge i_user_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        wr_grant  = 1'b0;
        rd_grant  = 1'b0;
        done_hit  = 1'b0;
        tout_hit  = 1'b0;
        case (state)
            IDLE: begin
                wr_grant  = i_wr_en && (!i_rd_en || !last_wr);
                rd_grant  = i_rd_en && (!i_wr_en || last_wr);
                state_nxt = (wr_grant || rd_grant) ? ISSUE : IDLE;
            end
            ISSUE: state_nxt = i_axi_cmd_ready ? WAIT : ISSUE;
            WAIT: begin
                // a matching done on the last allowed cycle beats the timeout
                done_hit  = o_axi_cmd_wr ? i_axi_wr_done : i_axi_rd_done;
                tout_hit  = !done_hit && (wait_cnt == L_TOUT_LAST);
                state_nxt = (done_hit || tout_hit) ? IDLE : WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_user_clk or posedge i_rst) begin
        if (i_rst) begin
            last_wr          <= 1'b0;
            o_axi_cmd_wr     <= 1'b0;
            o_axi_cmd_addr   <= '0;
            o_axi_cmd_length <= '0;
            wait_cnt         <= '0;
            o_timeout        <= 1'b0;
        end else begin
            if (wr_grant || rd_grant) begin
                last_wr          <= wr_grant;
                o_axi_cmd_wr     <= wr_grant;
                o_axi_cmd_addr   <= wr_grant ? i_wr_addr : i_rd_addr;
                o_axi_cmd_length <= wr_grant ? i_wr_length : i_rd_length;
            end
            wait_cnt  <= (state == WAIT) ? wait_cnt + 16'd1 : 16'd0;
            o_timeout <= tout_hit;
        end
    end
    assign o_wr_ready      = wr_grant;
    assign o_rd_ready      = rd_grant;
    assign o_axi_cmd_valid = (state == ISSUE);
    assign o_busy          = (state != IDLE);
endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// tb_axi_cmd_arbiter: vector table, directed corner sequences and random traffic
// checked against a transaction-level reference model.
module tb_axi_cmd_arbiter;
    localparam int AW = 32;
    localparam int TO = 16;
    typedef struct {
        logic          wr_en, rd_en;
        logic [AW-1:0] wr_addr, rd_addr;
        logic [7:0]    wr_len, rd_len;
        logic          cmd_ready, wr_done, rd_done;
    } stim_t;
    typedef struct {
        stim_t s;
        logic  wr_rdy, rd_rdy, valid, busy, cmd_wr;
    } vec_t;
    logic          clk = 1'b0, rst = 1'b0;
    logic          i_wr_en = 0, i_rd_en = 0, i_axi_cmd_ready = 0, i_axi_wr_done = 0, i_axi_rd_done = 0;
    logic [AW-1:0] i_wr_addr = '0, i_rd_addr = '0;
    logic [7:0]    i_wr_length = '0, i_rd_length = '0;
    logic          o_wr_ready, o_rd_ready, o_axi_cmd_valid, o_axi_cmd_wr, o_busy, o_timeout;
    logic [AW-1:0] o_axi_cmd_addr;
    logic [7:0]    o_axi_cmd_length;
    int            n_cmp = 0, n_bad = 0;
    bit            m_pend, m_acc, m_wr, m_last_wr, m_tout;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_len;
    int            m_waited;
    vec_t          tbl[10];
    always #5 clk = ~clk;
    axi_cmd_arbiter #(.P_AXI_ADDR_WIDTH(AW), .P_TIMEOUT(TO)) dut (
        .i_user_clk(clk), .i_rst(rst),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_length(i_wr_length), .o_wr_ready(o_wr_ready),
        .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .i_rd_length(i_rd_length), .o_rd_ready(o_rd_ready),
        .o_axi_cmd_valid(o_axi_cmd_valid), .o_axi_cmd_wr(o_axi_cmd_wr), .o_axi_cmd_addr(o_axi_cmd_addr),
        .o_axi_cmd_length(o_axi_cmd_length), .i_axi_cmd_ready(i_axi_cmd_ready),
        .i_axi_wr_done(i_axi_wr_done), .i_axi_rd_done(i_axi_rd_done), .o_busy(o_busy), .o_timeout(o_timeout)
    );
    function automatic stim_t mk(input logic we, input logic [AW-1:0] wa, input logic [7:0] wl,
                                 input logic re, input logic [AW-1:0] ra, input logic [7:0] rl,
                                 input logic cr, input logic wd, input logic rd);
        stim_t s;
        s.wr_en = we; s.wr_addr = wa; s.wr_len = wl;
        s.rd_en = re; s.rd_addr = ra; s.rd_len = rl;
        s.cmd_ready = cr; s.wr_done = wd; s.rd_done = rd;
        return s;
    endfunction
    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_pend = 0; m_acc = 0; m_wr = 0; m_last_wr = 0; m_tout = 0;
        m_addr = '0; m_len = '0; m_waited = 0;
    endtask
    task automatic drive(input stim_t s);
        bit wg, rg;
        @(negedge clk);
        i_wr_en = s.wr_en; i_wr_addr = s.wr_addr; i_wr_length = s.wr_len;
        i_rd_en = s.rd_en; i_rd_addr = s.rd_addr; i_rd_length = s.rd_len;
        i_axi_cmd_ready = s.cmd_ready; i_axi_wr_done = s.wr_done; i_axi_rd_done = s.rd_done;
        #2;
        wg = !m_pend && s.wr_en && (!s.rd_en || !m_last_wr);
        rg = !m_pend && s.rd_en && (!s.wr_en || m_last_wr);
        chk("wr_ready", o_wr_ready, wg);
        chk("rd_ready", o_rd_ready, rg);
        chk("valid", o_axi_cmd_valid, m_pend && !m_acc);
        chk("busy", o_busy, m_pend);
        chk("cmd_wr", o_axi_cmd_wr, m_wr);
        chk("cmd_addr", o_axi_cmd_addr, m_addr);
        chk("cmd_len", o_axi_cmd_length, m_len);
        chk("timeout", o_timeout, m_tout);
        m_tout = 0;
        if (!m_pend) begin
            if (wg || rg) begin
                m_pend = 1; m_acc = 0; m_wr = wg; m_last_wr = wg;
                m_addr = wg ? s.wr_addr : s.rd_addr;
                m_len  = wg ? s.wr_len : s.rd_len;
            end
        end else if (!m_acc) begin
            if (s.cmd_ready) begin m_acc = 1; m_waited = 0; end
        end else if (m_wr ? s.wr_done : s.rd_done) m_pend = 0;
        else if (m_waited == TO - 1) begin m_pend = 0; m_tout = 1; end
        else m_waited++;
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        i_wr_en = 0; i_rd_en = 0; i_axi_cmd_ready = 0; i_axi_wr_done = 0; i_axi_rd_done = 0;
        #2;
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_axi_cmd_valid, 0);
        chk("rst_addr", o_axi_cmd_addr, 0);
        chk("rst_len", o_axi_cmd_length, 0);
        chk("rst_wr", o_axi_cmd_wr, 0);
        chk("rst_timeout", o_timeout, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask
    initial begin
        stim_t idle, wr1, rd1, both;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        wr1  = mk(1, 32'h0000_1000, 8'hFF, 0, 32'h0000_2000, 8'h10, 0, 0, 0);
        rd1  = mk(0, 32'h0000_1000, 8'hFF, 1, 32'h0000_2000, 8'h10, 0, 0, 0);
        both = mk(1, 32'h0000_1000, 8'hFF, 1, 32'h0000_2000, 8'h10, 0, 0, 0);
        tbl[0] = '{both, 1, 0, 0, 0, 0};
        tbl[1] = '{idle, 0, 0, 1, 1, 1};
        tbl[2] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 0, 0, 1, 1, 1};
        tbl[3] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 1, 1};
        tbl[4] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 0, 0, 0, 1, 1};
        tbl[5] = '{both, 0, 1, 0, 0, 1};
        tbl[6] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 0, 0, 1, 1, 0};
        tbl[7] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 0, 0, 0, 1, 0};
        tbl[8] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 1, 0};
        tbl[9] = '{idle, 0, 0, 0, 0, 0};
        model_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].s);
            chk($sformatf("tbl%0d_wr_ready", i), o_wr_ready, tbl[i].wr_rdy);
            chk($sformatf("tbl%0d_rd_ready", i), o_rd_ready, tbl[i].rd_rdy);
            chk($sformatf("tbl%0d_valid", i), o_axi_cmd_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].busy);
            chk($sformatf("tbl%0d_cmd_wr", i), o_axi_cmd_wr, tbl[i].cmd_wr);
        end
        drive(wr1);
        chk("slow_grant", o_wr_ready, 1);
        for (int i = 0; i < 3; i++) begin
            drive(idle);
            chk("slow_valid", o_axi_cmd_valid, 1);
            chk("slow_addr", o_axi_cmd_addr, 32'h0000_1000);
            chk("slow_len", o_axi_cmd_length, 8'hFF);
        end
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        drive(idle);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        drive(idle);
        chk("slow_done_busy", o_busy, 0);
        drive(wr1);
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < TO; i++) begin
            drive(rd1);
            chk("to_wait_no_pulse", o_timeout, 0);
            chk("to_wait_busy", o_busy, 1);
        end
        drive(rd1);
        chk("to_pulse", o_timeout, 1);
        chk("to_rd_grant", o_rd_ready, 1);
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        drive(wr1);
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < TO - 1; i++) drive(idle);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        drive(idle);
        chk("race_no_timeout", o_timeout, 0);
        chk("race_idle", o_busy, 0);
        drive(wr1);
        @(negedge clk);
        #2;
        chk("arst_pre_valid", o_axi_cmd_valid, 1);
        rst = 1;
        i_wr_en = 0; i_rd_en = 0; i_axi_cmd_ready = 0; i_axi_wr_done = 0; i_axi_rd_done = 0;
        #1;
        chk("arst_valid", o_axi_cmd_valid, 0);
        chk("arst_busy", o_busy, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        drive(both);
        chk("arst_wr_first", o_wr_ready, 1);
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        drive(both);
        chk("arst_then_rd", o_rd_ready, 1);
        for (int i = 0; i < 3000; i++)
            drive(mk($urandom_range(0, 1), $urandom, 8'($urandom), $urandom_range(0, 1), $urandom, 8'($urandom),
                     $urandom_range(0, 1), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
